fetch_queue: RTL

- Producer side of the fetch→decode interface. Three lock-stepped FIFOs (instruction, PC, predicted branch target) share one set of pointers.
- Fetch enqueues one entry per cycle. Decode sees the head entry on `iq_rdata`, `pcq_rdata` and `bpq_rdata`, and pops it with `deq`.
- `flush` empties the queue on branch mispredict recovery.

---
 rtl/fetch_queue.sv | 88 ++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Fetch-to-decode queue: three lock-stepped 32-bit FIFOs (instruction, PC,
// predicted target) sharing one pair of wrap-bit pointers, with show-ahead read.

module fetch_queue_lane #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [31:0]      rdata
);
  // Storage is intentionally unreset; the head is masked while empty.
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

module fetch_queue #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             enq,
  input  logic [31:0]      enq_inst,
  input  logic [31:0]      enq_pc,
  input  logic [31:0]      enq_bp_target,
  output logic             full,
  input  logic             deq,
  output logic [31:0]      iq_rdata,
  output logic [31:0]      pcq_rdata,
  output logic [31:0]      bpq_rdata,
  output logic             empty,
  output logic [PTR_W:0]   count
);
  localparam int NUM_Q = 3;

  logic [PTR_W:0]             wptr, rptr;
  logic                       enq_ok, deq_ok;
  logic [NUM_Q-1:0][31:0]     wdata, lane_rdata;

  // Flags depend only on registered pointers, never on enq/deq.
  assign empty  = (wptr == rptr);
  assign full   = (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]) && (wptr[PTR_W] != rptr[PTR_W]);
  assign count  = wptr - rptr;

  assign enq_ok = enq && !full  && !flush;
  assign deq_ok = deq && !empty && !flush;

  assign wdata  = {enq_bp_target, enq_pc, enq_inst};

  for (genvar g = 0; g < NUM_Q; g++) begin : g_lane
    fetch_queue_lane #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_lane (
      .clk   (clk),
      .we    (enq_ok),
      .waddr (wptr[PTR_W-1:0]),
      .wdata (wdata[g]),
      .raddr (rptr[PTR_W-1:0]),
      .rdata (lane_rdata[g])
    );
  end

  assign iq_rdata  = empty ? 32'h0 : lane_rdata[0];
  assign pcq_rdata = empty ? 32'h0 : lane_rdata[1];
  assign bpq_rdata = empty ? 32'h0 : lane_rdata[2];

  // Pointer overflow past 2^(PTR_W+1) is the wrap; no special case needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (enq_ok) wptr <= wptr + 1'b1;
      if (deq_ok) rptr <= rptr + 1'b1;
    end
  end
endmodule
